// File: rtl/router_pkt_source.sv
// Router ingress packet source: buffers a request's payload, then streams
// header, payload and even XOR parity to the router with no gaps, honoring busy.
module router_pkt_source #(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic       inject_err,
  output logic       start_ready,
  input  logic [7:0] pay_data,
  input  logic       pay_valid,
  output logic       pay_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       packet_valid,
  output logic       tx_active,
  output logic       done,
  output logic       bad_req,
  output logic [2:0] state_dbg_o
);

  // Handshakes: a request transfers on a rising edge with start && start_ready,
  // a payload byte on pay_valid && pay_ready, and an output byte when busy=0
  // while tx_active=1; an untransferred item is held unchanged.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
  } state_t;

  localparam logic [6:0] MAX_L    = 7'(MAX_LEN);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state_q;
  logic [1:0] dest_q;
  logic [5:0] len_q;
  logic       inj_q;
  logic [5:0] wr_q;
  logic [5:0] rd_q;
  logic [7:0] par_q;
  logic [7:0] gap_q;
  logic       bad_q;
  logic [7:0] mem_q [MAX_LEN];

  logic req_bad;
  logic write_en;
  logic last_wr;
  logic last_rd;

  assign req_bad  = (dest == 2'd3) || ({1'b0, len} > MAX_L);
  assign write_en = (state_q == S_LOAD) && pay_valid;
  assign last_wr  = (wr_q == len_q - 6'd1);
  assign last_rd  = (rd_q == len_q - 6'd1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      dest_q  <= 2'd0;
      len_q   <= 6'd0;
      inj_q   <= 1'b0;
      wr_q    <= 6'd0;
      rd_q    <= 6'd0;
      par_q   <= 8'd0;
      gap_q   <= 8'd0;
      bad_q   <= 1'b0;
    end else begin
      bad_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (req_bad) begin
              bad_q <= 1'b1;
            end else begin
              dest_q  <= dest;
              len_q   <= len;
              inj_q   <= inject_err;
              par_q   <= {len, dest};
              wr_q    <= 6'd0;
              rd_q    <= 6'd0;
              state_q <= (len == 6'd0) ? S_HEADER : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (pay_valid) begin
            par_q <= par_q ^ pay_data;
            wr_q  <= wr_q + 6'd1;
            if (last_wr) state_q <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (!busy) begin
            rd_q    <= 6'd0;
            state_q <= (len_q == 6'd0) ? S_PARITY : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            if (last_rd) state_q <= S_PARITY;
            else         rd_q    <= rd_q + 6'd1;
          end
        end
        S_PARITY: begin
          if (!busy) begin
            gap_q   <= 8'd0;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) state_q <= S_IDLE;
          else                   gap_q   <= gap_q + 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so the array is not reset.
  always_ff @(posedge clk) begin
    if (write_en) mem_q[wr_q] <= pay_data;
  end

  always_comb begin
    data_out = 8'd0;
    case (state_q)
      S_HEADER:  data_out = {len_q, dest_q};
      S_PAYLOAD: data_out = mem_q[rd_q];
      S_PARITY:  data_out = par_q ^ {7'b0, inj_q};
      default:   data_out = 8'd0;
    endcase
  end

  assign start_ready  = (state_q == S_IDLE);
  assign pay_ready    = (state_q == S_LOAD);
  assign packet_valid = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
  assign tx_active    = packet_valid || (state_q == S_PARITY);
  assign done         = (state_q == S_GAP) && (gap_q == 8'd0);
  assign bad_req      = bad_q;
  assign state_dbg_o  = state_q;

endmodule

// File: doc/router_pkt_source.md
Name: router_pkt_source

Overview:
- Packet transmitter that drives the router input port with header, payload and parity bytes.
- Upstream logic issues a request (dest, len), then supplies len payload bytes over a valid/ready stream. The block buffers the payload, then transmits the full packet with no gaps.
- Honors router busy; generates even byte-wise XOR parity.
- Used as the ingress source in the router subsystem and as a reusable bench driver.

Parameters:
- MAX_LEN, 63: max payload bytes; buffer depth. Must be ≤63 (6-bit length field).
- GAP_CYCLES, 2: idle cycles after parity before the next request is accepted. Minimum 1.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- start  in  1  request strobe, sampled when start_ready=1
- dest  in  2  destination channel 0..2; 3 is illegal
- len  in  6  payload length 0..MAX_LEN
- inject_err  in  1  when latched at start, inverts parity bit 0
- start_ready  out  1  high in IDLE only
- pay_data  in  8  payload byte
- pay_valid  in  1  payload byte valid
- pay_ready  out  1  high in LOAD only
- busy  in  1  router busy; byte on data_out is accepted on a rising edge with busy=0
- data_out  out  8  router data_in
- packet_valid  out  1  router packet_valid
- tx_active  out  1  high in HEADER/PAYLOAD/PARITY
- done  out  1  one-cycle pulse on first GAP cycle
- bad_req  out  1  one-cycle pulse for a rejected request

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk.
  - Reset forces state IDLE and clears all counters, parity, and latched dest/len/inject.
  - All outputs read 0 in reset, except start_ready, which is 1 from the first cycle after reset.
  - Reset mid-packet aborts the packet. No parity is sent. Buffer contents are don't-care.
- Output timing: all outputs are Moore, decoded from state and internal registers. There is no combinational path from busy, start or pay_valid to any output.
- Header byte = {len[5:0], dest[1:0]}.
- Parity register:
  - Loads the header at request accept.
  - XORs in each payload byte at buffer write.
  - Transmitted parity = parity ^ {7'b0, inject}.
- IDLE:
  - start_ready=1, packet_valid=0, data_out=0.
  - start && dest==3: bad_req pulses next cycle; stay IDLE; nothing latched.
  - start && len>MAX_LEN: treated the same as dest==3 (bad_req, stay IDLE).
  - Legal start: latch dest, len, inject.
    - len==0: go to HEADER.
    - len>0: go to LOAD.
- LOAD:
  - pay_ready=1. Each pay_valid&&pay_ready writes buf[wr_cnt] and increments wr_cnt.
  - The write with wr_cnt==len-1 goes to HEADER.
  - pay_valid low simply waits; there is no timeout.
- HEADER: data_out=header, packet_valid=1.
  - On edge with busy=0: rd_cnt←0.
    - len>0: go to PAYLOAD.
    - len==0: go to PARITY.
  - busy=1 holds the header unchanged.
- PAYLOAD: data_out=buf[rd_cnt], packet_valid=1.
  - On edge with busy=0: rd_cnt++.
  - When rd_cnt==len-1, go to PARITY.
  - busy=1 holds the byte; bytes are never skipped or duplicated.
- PARITY: data_out=transmitted parity, packet_valid=0.
  - Held until an edge with busy=0, then go to GAP.
- GAP:
  - packet_valid=0, data_out=0, done=1 on the first cycle only.
  - After GAP_CYCLES cycles, go to IDLE.
- Ignored inputs:
  - start outside IDLE is ignored.
  - pay_valid outside LOAD is ignored (pay_ready=0).
- Width: wr_cnt and rd_cnt are 6-bit and never wrap in legal operation, since len ≤ 63.
- Latency: with busy=0, the header appears 1 cycle after the last payload write (len>0) or after start (len==0). One byte is transmitted per cycle thereafter.

Test Plan:
- Basic packet, busy=0:
  - Stimulus: dest=1, len=3, payload A1,B2,C3.
  - data_out sequence 0x0D, A1, B2, C3 with packet_valid=1.
  - Then 0xDD with packet_valid=0.
  - done pulses once, then 2 gap cycles, then start_ready=1.
- Busy stall: same packet with busy=1 for 3 cycles while B2 is presented.
  - B2 is held 4 cycles; no byte is lost or repeated; parity is still 0xDD.
- Zero length: dest=2, len=0.
  - pay_ready never asserts.
  - data_out 0x02 with packet_valid=1, then parity 0x02 with packet_valid=0.
- Illegal request: dest=3, len=5.
  - bad_req pulses 1 cycle; state stays IDLE; pay_ready stays 0.
  - A following legal request is processed normally.
- Error injection: the basic packet with inject_err=1.
  - Parity byte is 0xDC; the next packet without inject has correct parity.
- Reset and max length:
  - resetn=0 during the 2nd PAYLOAD byte: next cycle all outputs are 0 and start_ready=1.
  - A subsequent len=63 packet streams 63 bytes back-to-back.
  - Its parity equals the XOR of the header and all 63 payload bytes.
